// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALU select codes, opcodes, operand sources.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package riscv_ex_pkg;

    localparam logic [3:0] ALU_SEL_AND   = 4'b0000;
    localparam logic [3:0] ALU_SEL_OR    = 4'b0001;
    localparam logic [3:0] ALU_SEL_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SEL_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SEL_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SEL_SRL   = 4'b1001;
    localparam logic [3:0] ALU_SEL_PASSB = 4'b1010;
    localparam logic [3:0] ALU_SEL_SRA   = 4'b1011;
    localparam logic [3:0] ALU_SEL_XOR   = 4'b1100;
    localparam logic [3:0] ALU_SEL_SLL   = 4'b1101;
    localparam logic [3:0] ALU_SEL_SLTU  = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        A_SRC_RS1  = 2'd0,
        A_SRC_PC   = 2'd1,
        A_SRC_ZERO = 2'd2
    } a_src_e;

    typedef enum logic {
        B_SRC_RS2 = 1'b0,
        B_SRC_IMM = 1'b1
    } b_src_e;

    // Shift operations only look at the low five bits of operand B.
    function automatic logic is_shift_sel(input logic [3:0] sel);
        return (sel == ALU_SEL_SLL) || (sel == ALU_SEL_SRL) || (sel == ALU_SEL_SRA);
    endfunction

endpackage

// File: rtl/id_ex_stage_alu_sel_decode.sv
// Instruction fields to ALU select, operand sources and sideband flags.
// Latency: purely combinational.
// Backpressure: none; evaluated on whatever fields are presented.
module alu_sel_decode
    import riscv_ex_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] sel_o,
    output a_src_e     a_src_o,
    output b_src_e     b_src_o,
    output logic       we_o,
    output logic       is_branch_o,
    output logic       illegal_o
);

    // Shared OP/OP-IMM map; alt selects SUB/SRA where the caller allows it.
    function automatic logic [3:0] arith_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SEL_SUB : ALU_SEL_ADD;
            3'b001:  return ALU_SEL_SLL;
            3'b010:  return ALU_SEL_SLT;
            3'b011:  return ALU_SEL_SLTU;
            3'b100:  return ALU_SEL_XOR;
            3'b101:  return alt ? ALU_SEL_SRA : ALU_SEL_SRL;
            3'b110:  return ALU_SEL_OR;
            default: return ALU_SEL_AND;
        endcase
    endfunction

    // Opcode decode; unknown opcodes fall to illegal with ADD and no writeback.
    always_comb begin
        sel_o       = ALU_SEL_ADD;
        a_src_o     = A_SRC_RS1;
        b_src_o     = B_SRC_RS2;
        we_o        = 1'b0;
        is_branch_o = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OPC_OP: begin
                sel_o = arith_sel(funct3_i, funct7b5_i);
                we_o  = 1'b1;
            end
            OPC_OP_IMM: begin
                // No SUBI: funct7b5 only distinguishes SRAI from SRLI.
                sel_o   = arith_sel(funct3_i, funct7b5_i && (funct3_i == 3'b101));
                b_src_o = B_SRC_IMM;
                we_o    = 1'b1;
            end
            OPC_LUI: begin
                sel_o   = ALU_SEL_PASSB;
                a_src_o = A_SRC_ZERO;
                b_src_o = B_SRC_IMM;
                we_o    = 1'b1;
            end
            OPC_AUIPC: begin
                a_src_o = A_SRC_PC;
                b_src_o = B_SRC_IMM;
                we_o    = 1'b1;
            end
            OPC_LOAD: begin
                b_src_o = B_SRC_IMM;
                we_o    = 1'b1;
            end
            OPC_STORE: begin
                b_src_o = B_SRC_IMM;
            end
            OPC_BRANCH: begin
                is_branch_o = 1'b1;
                case (funct3_i[2:1])
                    2'b10:   sel_o = ALU_SEL_SLT;
                    2'b11:   sel_o = ALU_SEL_SLTU;
                    default: sel_o = ALU_SEL_SUB;
                endcase
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register: decodes at capture and presents ALU select, operands and sideband to execute.
// Latency: 1 cycle; accept-and-drain in the same cycle keeps full throughput.
// Backpressure: in_ready = !out_valid || out_ready; held outputs stay stable. Optional ID_EX_FWD_EN adds operand forwarding.
module id_ex_stage
    import riscv_ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_sel,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_is_branch,
    output logic [2:0]      out_funct3,
    output logic            out_illegal
`ifdef ID_EX_FWD_EN
    ,
    input  logic            fwd_exm_we,
    input  logic [4:0]      fwd_exm_rd,
    input  logic [XLEN-1:0] fwd_exm_data,
    input  logic            fwd_wb_we,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data
`endif
);

    logic [3:0]      dec_sel;
    a_src_e          dec_a_src;
    b_src_e          dec_b_src;
    logic            dec_we, dec_branch, dec_illegal;
    logic [XLEN-1:0] cap_a, cap_b;
    logic            accept;

    logic            valid_q, valid_d;
    logic [3:0]      sel_q, sel_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [4:0]      rd_q, rd_d;
    logic            we_q, we_d, br_q, br_d, ill_q, ill_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] a_opnd, b_opnd;
`ifdef ID_EX_FWD_EN
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d;
    logic            a_rs1_q, a_rs1_d, b_rs2_q, b_rs2_d;
`else
    logic            unused_rs_addrs;
    assign unused_rs_addrs = ^{in_rs1_addr, in_rs2_addr};
`endif

    alu_sel_decode u_dec (
        .opcode_i    (in_opcode),
        .funct3_i    (in_funct3),
        .funct7b5_i  (in_funct7b5),
        .sel_o       (dec_sel),
        .a_src_o     (dec_a_src),
        .b_src_o     (dec_b_src),
        .we_o        (dec_we),
        .is_branch_o (dec_branch),
        .illegal_o   (dec_illegal)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Resolve the operand values to store from the decoded sources.
    always_comb begin
        cap_a = '0;
        case (dec_a_src)
            A_SRC_RS1: cap_a = in_rs1_data;
            A_SRC_PC:  cap_a = in_pc;
            default:   cap_a = '0;
        endcase
        cap_b = (dec_b_src == B_SRC_IMM) ? in_imm : in_rs2_data;
    end

    // Next state: flush wins over accept; a flushed accept never loads the entry.
    always_comb begin
        valid_d = valid_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        we_d    = we_q;
        br_d    = br_q;
        ill_d   = ill_q;
        f3_d    = f3_q;
`ifdef ID_EX_FWD_EN
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        a_rs1_d = a_rs1_q;
        b_rs2_d = b_rs2_q;
`endif
        if (flush)          valid_d = 1'b0;
        else if (accept)    valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;

        if (accept && !flush) begin
            sel_d   = dec_sel;
            a_d     = cap_a;
            b_d     = cap_b;
            rd_d    = in_rd_addr;
            we_d    = dec_we && (in_rd_addr != 5'd0);
            br_d    = dec_branch;
            ill_d   = dec_illegal;
            f3_d    = in_funct3;
`ifdef ID_EX_FWD_EN
            rs1_d   = in_rs1_addr;
            rs2_d   = in_rs2_addr;
            a_rs1_d = (dec_a_src == A_SRC_RS1);
            b_rs2_d = (dec_b_src == B_SRC_RS2);
`endif
        end
    end

    // Entry register, cleared asynchronously so outputs drop to zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
            f3_q    <= '0;
`ifdef ID_EX_FWD_EN
            rs1_q   <= '0;
            rs2_q   <= '0;
            a_rs1_q <= 1'b0;
            b_rs2_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
            f3_q    <= f3_d;
`ifdef ID_EX_FWD_EN
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            a_rs1_q <= a_rs1_d;
            b_rs2_q <= b_rs2_d;
`endif
        end
    end

    // Late operand mux: EX/MEM beats WB, x0 never forwards, re-evaluated while stalled.
    always_comb begin
        a_opnd = a_q;
        b_opnd = b_q;
`ifdef ID_EX_FWD_EN
        if (a_rs1_q && (rs1_q != 5'd0)) begin
            if (fwd_exm_we && (fwd_exm_rd == rs1_q))    a_opnd = fwd_exm_data;
            else if (fwd_wb_we && (fwd_wb_rd == rs1_q)) a_opnd = fwd_wb_data;
        end
        if (b_rs2_q && (rs2_q != 5'd0)) begin
            if (fwd_exm_we && (fwd_exm_rd == rs2_q))    b_opnd = fwd_exm_data;
            else if (fwd_wb_we && (fwd_wb_rd == rs2_q)) b_opnd = fwd_wb_data;
        end
`endif
    end

    assign out_valid     = valid_q;
    assign out_alu_sel   = sel_q;
    assign out_a         = a_opnd;
    // Shift amount masking happens after forwarding so forwarded values are masked too.
    assign out_b         = is_shift_sel(sel_q) ? {{(XLEN-5){1'b0}}, b_opnd[4:0]} : b_opnd;
    assign out_rd        = rd_q;
    assign out_we        = we_q;
    assign out_is_branch = br_q;
    assign out_funct3    = f3_q;
    assign out_illegal   = ill_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by randomized traffic against a behavioural model.
// Latency: checks outputs one edge after each accept.
// Backpressure: exercises stalls, flushes and same-cycle accept/drain.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic        flush;
    logic        out_valid, out_ready;
    logic [3:0]  out_alu_sel;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_rd;
    logic        out_we, out_is_branch, out_illegal;
    logic [2:0]  out_funct3;
    logic        fwd_exm_we, fwd_wb_we;
    logic [4:0]  fwd_exm_rd, fwd_wb_rd;
    logic [31:0] fwd_exm_data, fwd_wb_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct3     (in_funct3),
        .in_funct7b5   (in_funct7b5),
        .in_rs1_addr   (in_rs1_addr),
        .in_rs2_addr   (in_rs2_addr),
        .in_rd_addr    (in_rd_addr),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_imm        (in_imm),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_sel   (out_alu_sel),
        .out_a         (out_a),
        .out_b         (out_b),
        .out_rd        (out_rd),
        .out_we        (out_we),
        .out_is_branch (out_is_branch),
        .out_funct3    (out_funct3),
        .out_illegal   (out_illegal)
`ifdef ID_EX_FWD_EN
        ,
        .fwd_exm_we    (fwd_exm_we),
        .fwd_exm_rd    (fwd_exm_rd),
        .fwd_exm_data  (fwd_exm_data),
        .fwd_wb_we     (fwd_wb_we),
        .fwd_wb_rd     (fwd_wb_rd),
        .fwd_wb_data   (fwd_wb_data)
`endif
    );

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rs1a, rs2a, rd;
        logic [31:0] rs1d, rs2d, imm, pc;
    } txn_t;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a, b;
        logic        a_rs1, b_rs2, shamt;
        logic [4:0]  rs1a, rs2a, rd;
        logic        we, br, ill;
        logic [2:0]  f3;
    } exp_t;

    // Reference: what execute should see for an instruction, straight from the ISA rules.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        logic [3:0] tab [8];
        tab = '{4'b0010, 4'b1101, 4'b0111, 4'b1111, 4'b1100, 4'b1001, 4'b0001, 4'b0000};
        e.sel = 4'b0010; e.a = 32'd0; e.b = 32'd0;
        e.a_rs1 = 1'b0; e.b_rs2 = 1'b0; e.shamt = 1'b0;
        e.rs1a = t.rs1a; e.rs2a = t.rs2a; e.rd = t.rd; e.f3 = t.f3;
        e.we = 1'b0; e.br = 1'b0; e.ill = 1'b0;
        case (t.opc)
            7'b0110011: begin
                e.a = t.rs1d; e.b = t.rs2d; e.a_rs1 = 1'b1; e.b_rs2 = 1'b1; e.we = 1'b1;
                e.sel = tab[t.f3];
                if (t.f7 && t.f3 == 3'd0) e.sel = 4'b0110;
                if (t.f7 && t.f3 == 3'd5) e.sel = 4'b1011;
                e.shamt = (t.f3 == 3'd1) || (t.f3 == 3'd5);
            end
            7'b0010011: begin
                e.a = t.rs1d; e.b = t.imm; e.a_rs1 = 1'b1; e.we = 1'b1;
                e.sel = tab[t.f3];
                if (t.f7 && t.f3 == 3'd5) e.sel = 4'b1011;
                e.shamt = (t.f3 == 3'd1) || (t.f3 == 3'd5);
            end
            7'b0110111: begin e.b = t.imm; e.sel = 4'b1010; e.we = 1'b1; end
            7'b0010111: begin e.a = t.pc; e.b = t.imm; e.we = 1'b1; end
            7'b0000011: begin e.a = t.rs1d; e.a_rs1 = 1'b1; e.b = t.imm; e.we = 1'b1; end
            7'b0100011: begin e.a = t.rs1d; e.a_rs1 = 1'b1; e.b = t.imm; end
            7'b1100011: begin
                e.a = t.rs1d; e.b = t.rs2d; e.a_rs1 = 1'b1; e.b_rs2 = 1'b1; e.br = 1'b1;
                e.sel = (t.f3 < 3'd4) ? 4'b0110 : (t.f3 < 3'd6) ? 4'b0111 : 4'b1111;
            end
            default: e.ill = 1'b1;
        endcase
        if (t.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    // Operand as seen after any forwarding from the buses currently driven.
    function automatic logic [31:0] opnd(input logic [31:0] raw, input logic is_reg, input logic [4:0] addr);
        logic [31:0] v;
        v = raw;
`ifdef ID_EX_FWD_EN
        if (is_reg && addr != 5'd0) begin
            if (fwd_exm_we && fwd_exm_rd == addr)     v = fwd_exm_data;
            else if (fwd_wb_we && fwd_wb_rd == addr)  v = fwd_wb_data;
        end
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input txn_t t, input logic v);
        in_valid    = v;
        in_opcode   = t.opc;  in_funct3   = t.f3;   in_funct7b5 = t.f7;
        in_rs1_addr = t.rs1a; in_rs2_addr = t.rs2a; in_rd_addr  = t.rd;
        in_rs1_data = t.rs1d; in_rs2_data = t.rs2d; in_imm      = t.imm; in_pc = t.pc;
    endtask

    task automatic check_held(input exp_t e, input string tag);
        logic [31:0] ea, eb;
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".sel"}, 32'(out_alu_sel), 32'(e.sel));
        chk({tag, ".rd"}, 32'(out_rd), 32'(e.rd));
        chk({tag, ".we"}, 32'(out_we), 32'(e.we));
        chk({tag, ".br"}, 32'(out_is_branch), 32'(e.br));
        chk({tag, ".f3"}, 32'(out_funct3), 32'(e.f3));
        chk({tag, ".ill"}, 32'(out_illegal), 32'(e.ill));
        if (!e.ill) begin
            ea = opnd(e.a, e.a_rs1, e.rs1a);
            eb = opnd(e.b, e.b_rs2, e.rs2a);
            if (e.shamt) eb = eb & 32'h1f;
            chk({tag, ".a"}, out_a, ea);
            chk({tag, ".b"}, out_b, eb);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".sel"}, 32'(out_alu_sel), 32'd0);
        chk({tag, ".a"}, out_a, 32'd0);
        chk({tag, ".b"}, out_b, 32'd0);
        chk({tag, ".side"}, 32'({out_rd, out_we, out_is_branch, out_funct3, out_illegal}), 32'd0);
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        logic [6:0] opcs [9];
        opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                 7'b0100011, 7'b1100011, 7'b1111111, 7'b0001111};
        t.opc  = opcs[$urandom_range(0, 8)];
        t.f3   = 3'($urandom);
        if (t.opc == 7'b1100011 && t.f3[2:1] == 2'b01) t.f3 = {2'b00, t.f3[0]};
        t.f7   = 1'($urandom);
        t.rs1a = 5'($urandom_range(0, 7));
        t.rs2a = 5'($urandom_range(0, 7));
        t.rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        t.rs1d = $urandom; t.rs2d = $urandom; t.imm = $urandom; t.pc = $urandom;
        return t;
    endfunction

    function automatic txn_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic [4:0] rs1a, input logic [31:0] rs1d,
                                input logic [31:0] rs2d, input logic [31:0] imm, input logic [4:0] rd);
        txn_t t;
        t.opc = opc; t.f3 = f3; t.f7 = f7; t.rs1a = rs1a; t.rs2a = 5'd2; t.rd = rd;
        t.rs1d = rs1d; t.rs2d = rs2d; t.imm = imm; t.pc = 32'h0000_1000;
        return t;
    endfunction

    initial begin
        txn_t t, ta, tb2;
        exp_t me;
        logic mv, rdy_exp, acc;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        fwd_exm_we = 1'b0; fwd_exm_rd = 5'd0; fwd_exm_data = 32'd0;
        fwd_wb_we = 1'b0;  fwd_wb_rd = 5'd0;  fwd_wb_data = 32'd0;
        t = mk(7'd0, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        apply(t, 1'b0);

        // Reset state
        #12;
        check_zero("reset");
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // SUB, accepted on the first edge after reset release
        rst = 1'b0;
        t = mk(7'b0110011, 3'b000, 1'b1, 5'd1, 32'd10, 32'd3, 32'd0, 5'd5);
        apply(t, 1'b1);
        tick();
        chk("sub.valid", 32'(out_valid), 32'd1);
        chk("sub.sel", 32'(out_alu_sel), 32'b0110);
        chk("sub.a", out_a, 32'd10);
        chk("sub.b", out_b, 32'd3);
        chk("sub.we", 32'(out_we), 32'd1);
        check_held(model(t), "sub");

        // SRAI back-to-back, shift amount masked
        t = mk(7'b0010011, 3'b101, 1'b1, 5'd1, 32'h8000_0000, 32'd0, 32'h0000_0405, 5'd6);
        apply(t, 1'b1);
        tick();
        chk("srai.sel", 32'(out_alu_sel), 32'b1011);
        chk("srai.b", out_b, 32'd5);
        chk("srai.a", out_a, 32'h8000_0000);
        check_held(model(t), "srai");

        // Backpressure: held entry stays stable, then accept on drain edge
        ta = mk(7'b0110111, 3'd0, 1'b0, 5'd3, 32'h1111, 32'h2222, 32'hABCD_E000, 5'd9);
        apply(ta, 1'b1);
        tick();
        out_ready = 1'b0;
        tb2 = mk(7'b0100011, 3'b010, 1'b0, 5'd4, 32'h100, 32'h5, 32'h10, 5'd0);
        apply(tb2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            tick();
            check_held(model(ta), "bp.hold");
        end
        out_ready = 1'b1;
        #1;
        chk("bp.drain_ready", 32'(in_ready), 32'd1);
        tick();
        check_held(model(tb2), "bp.next");

        // Flush while stalled with a new instruction presented
        out_ready = 1'b0;
        apply(ta, 1'b1);
        flush = 1'b1;
        tick();
        chk("flush_stall.valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_stall.after", 32'(out_valid), 32'd0);

        // Flush discards an entry accepted in the same cycle
        out_ready = 1'b1;
        apply(ta, 1'b1);
        tick();
        apply(tb2, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_acc.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("flush_acc.valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_acc.after", 32'(out_valid), 32'd0);

        // ADD with rs1=7 held; forwarding (if built) re-evaluated during the stall
        t = mk(7'b0110011, 3'b000, 1'b0, 5'd7, 32'd1, 32'd2, 32'd0, 5'd3);
        apply(t, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
`ifdef ID_EX_FWD_EN
        fwd_exm_we = 1'b1; fwd_exm_rd = 5'd7; fwd_exm_data = 32'hAA;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd7; fwd_wb_data  = 32'hBB;
        #1;
        chk("fwd.exm", out_a, 32'hAA);
        fwd_exm_we = 1'b0;
        #1;
        chk("fwd.wb", out_a, 32'hBB);
        fwd_wb_we = 1'b0;
        #1;
        chk("fwd.none", out_a, 32'd1);
        out_ready = 1'b1;
        t = mk(7'b0110011, 3'b000, 1'b0, 5'd0, 32'd5, 32'd2, 32'd0, 5'd3);
        apply(t, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        fwd_exm_we = 1'b1; fwd_exm_rd = 5'd0;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd0;
        #1;
        chk("fwd.x0", out_a, 32'd5);
        fwd_exm_we = 1'b0; fwd_wb_we = 1'b0;
`endif
        check_held(model(t), "held");

        // Asynchronous reset while stalled, then accept on the first edge after release
        #1;
        rst = 1'b1;
        #1;
        check_zero("rst_stall");
        chk("rst_stall.in_ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b0;
        t = mk(7'b0010111, 3'b000, 1'b0, 5'd1, 32'd0, 32'd0, 32'h0000_2000, 5'd8);
        apply(t, 1'b1);
        tick();
        check_held(model(t), "post_rst");
        in_valid = 1'b0;
        mv = 1'b1;
        me = model(t);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 400; cyc++) begin
            t = rand_txn();
            apply(t, $urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 15) == 0;
`ifdef ID_EX_FWD_EN
            fwd_exm_we = 1'($urandom); fwd_exm_rd = 5'($urandom_range(0, 7)); fwd_exm_data = $urandom;
            fwd_wb_we  = 1'($urandom); fwd_wb_rd  = 5'($urandom_range(0, 7)); fwd_wb_data  = $urandom;
`endif
            #1;
            rdy_exp = !mv || out_ready;
            chk("rnd.in_ready", 32'(in_ready), 32'(rdy_exp));
            acc = in_valid && rdy_exp;
            tick();
            if (flush)          mv = 1'b0;
            else if (acc)       begin mv = 1'b1; me = model(t); end
            else if (out_ready) mv = 1'b0;
            chk("rnd.valid", 32'(out_valid), 32'(mv));
            if (mv) check_held(me, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
